// File: rtl/reverb_pkg.sv
// -----------------------------------------------------------------------------
// reverb_pkg
// Shared definitions for the Reverb tap scheduler.
//   REVERB_ADDR_W   : default delay-line address width (depth = 2^ADDR_W)
//   REVERB_DATA_W   : default signed sample width
//   REVERB_NUM_TAPS : number of tap reads per sample
//   state_t         : scheduler sequence states
// -----------------------------------------------------------------------------
package reverb_pkg;

  localparam int REVERB_ADDR_W   = 12;
  localparam int REVERB_DATA_W   = 16;
  localparam int REVERB_NUM_TAPS = 3;

  // One RAM slot per state: a write, three reads, then a result/update slot.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    RD3  = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/reverb_tap_scheduler.sv
// -----------------------------------------------------------------------------
// reverb_tap_scheduler
// Time-multiplexes one single-port synchronous delay-line RAM between the
// per-sample write and three delayed tap reads. Each accepted sample is
// written at a circular write pointer; the three taps are then read back at
// (wr_ptr - delay) and presented together with a one-cycle taps_valid pulse.
//
// Ports:
//   clk           system clock
//   rst_          synchronous, active-low reset
//   sample_valid  one-cycle strobe, sample_in valid (ignored while busy)
//   sample_in     signed input sample
//   delay_time_k  tap k delay in samples (latched on acceptance)
//   mem_addr      RAM address
//   mem_we        RAM write enable
//   mem_wdata     RAM write data
//   mem_rdata     RAM read data, valid one cycle after the address
//   tapk_out      delayed sample for tap k
//   taps_valid    one-cycle pulse, tap outputs just updated
//   busy          sequence in progress
//   overrun       sticky: a sample arrived while busy and was dropped
// -----------------------------------------------------------------------------
module reverb_tap_scheduler
  import reverb_pkg::*;
#(
  parameter int ADDR_W = REVERB_ADDR_W,
  parameter int DATA_W = REVERB_DATA_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic [ADDR_W-1:0] delay_time_1,
  input  logic [ADDR_W-1:0] delay_time_2,
  input  logic [ADDR_W-1:0] delay_time_3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tap1_out,
  output logic [DATA_W-1:0] tap2_out,
  output logic [DATA_W-1:0] tap3_out,
  output logic              taps_valid,
  output logic              busy,
  output logic              overrun
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                                    state_reg;
  logic [ADDR_W-1:0]                         wr_ptr_reg;
  logic [ADDR_W-1:0]                         fill_cnt_reg;
  logic [DATA_W-1:0]                         sample_reg;
  logic [REVERB_NUM_TAPS-1:0][ADDR_W-1:0]    dly_reg;
  logic [REVERB_NUM_TAPS-1:0]                tap_ok_reg;
  logic [1:0][DATA_W-1:0]                    hold_reg;
  logic [REVERB_NUM_TAPS-1:0][DATA_W-1:0]    tap_reg;
  logic                                      taps_valid_reg;
  logic                                      overrun_reg;

  // ---------------------------------------------------------------------------
  // Per-tap helpers
  // ---------------------------------------------------------------------------
  logic [REVERB_NUM_TAPS-1:0][ADDR_W-1:0]    dly_in;
  logic [REVERB_NUM_TAPS-1:0][ADDR_W-1:0]    rd_addr;
  logic [REVERB_NUM_TAPS-1:0]                tap_ok_next;
  logic [REVERB_NUM_TAPS-1:0][DATA_W-1:0]    rdata_gated;

  assign dly_in = {delay_time_3, delay_time_2, delay_time_1};

  generate
    for (genvar gi = 0; gi < REVERB_NUM_TAPS; gi++) begin : g_tap
      // A tap may only reach back over samples actually written since reset;
      // fill_cnt counts those, so a longer delay would read stale RAM.
      assign tap_ok_next[gi] = (dly_in[gi] <= fill_cnt_reg);

      // wr_ptr still points at the slot of the current sample during the
      // reads, so delay 0 returns the sample just written. Wraps naturally.
      assign rd_addr[gi] = wr_ptr_reg - dly_reg[gi];

      assign rdata_gated[gi] = tap_ok_reg[gi] ? mem_rdata : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      fill_cnt_reg   <= '0;
      sample_reg     <= '0;
      dly_reg        <= '0;
      tap_ok_reg     <= '0;
      hold_reg       <= '0;
      tap_reg        <= '0;
      taps_valid_reg <= 1'b0;
      overrun_reg    <= 1'b0;
    end else begin
      taps_valid_reg <= 1'b0;

      // Any strobe outside IDLE (including DONE) is dropped.
      if (sample_valid && (state_reg != IDLE)) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (sample_valid) begin
            sample_reg <= sample_in;
            dly_reg    <= dly_in;
            tap_ok_reg <= tap_ok_next;
            state_reg  <= WR;
          end
        end

        WR:  state_reg <= RD1;

        RD1: state_reg <= RD2;

        // Read data arrives one cycle after its address: the RD1 read lands
        // here, the RD2 read lands in RD3, the RD3 read lands in DONE.
        RD2: begin
          hold_reg[0] <= rdata_gated[0];
          state_reg   <= RD3;
        end

        RD3: begin
          hold_reg[1] <= rdata_gated[1];
          state_reg   <= DONE;
        end

        // All three outputs change on the same edge so the mixer never sees
        // a mix of old and new taps.
        DONE: begin
          tap_reg        <= {rdata_gated[2], hold_reg[1], hold_reg[0]};
          wr_ptr_reg     <= wr_ptr_reg + ADDR_W'(1);
          if (fill_cnt_reg != '1) begin
            fill_cnt_reg <= fill_cnt_reg + ADDR_W'(1);
          end
          taps_valid_reg <= 1'b1;
          state_reg      <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port, decoded from the registered state
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_ptr_reg;
    mem_wdata = sample_reg;
    case (state_reg)
      WR:      mem_we   = 1'b1;
      RD1:     mem_addr = rd_addr[0];
      RD2:     mem_addr = rd_addr[1];
      RD3:     mem_addr = rd_addr[2];
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign tap1_out   = tap_reg[0];
  assign tap2_out   = tap_reg[1];
  assign tap3_out   = tap_reg[2];
  assign taps_valid = taps_valid_reg;
  assign busy       = (state_reg != IDLE);
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_reverb_tap_scheduler.sv
// -----------------------------------------------------------------------------
// tb_reverb_tap_scheduler
// Two scheduler instances (ADDR_W=12 and ADDR_W=4) share one stimulus stream.
// Each has its own 1-cycle-latency RAM model, a history-based reference model
// that predicts writes and taps, and a monitor that checks them.
// -----------------------------------------------------------------------------
module tb_reverb_tap_scheduler;

  logic        clk = 1'b0;
  logic        rst_;
  logic        sample_valid;
  logic [15:0] sample_in;
  logic [11:0] d1, d2, d3;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  typedef struct {
    longint t1;
    longint t2;
    longint t3;
    int     cyc;
  } tap_exp_t;

  typedef struct {
    int     addr;
    longint data;
    int     cyc;
  } wr_exp_t;

  task automatic chk(input string name, input int inst,
                     input logic signed [63:0] act, input logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d, expected %0d", name, inst, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // DUT instances with RAM, reference model and monitor
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int AW    = (gi == 0) ? 12 : 4;
    localparam int DEPTH = 1 << AW;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic [15:0]   tap1, tap2, tap3;
    logic          taps_valid, busy, overrun;

    reverb_tap_scheduler #(.ADDR_W(AW), .DATA_W(16)) dut (
      .clk          (clk),
      .rst_         (rst_),
      .sample_valid (sample_valid),
      .sample_in    (sample_in),
      .delay_time_1 (d1[AW-1:0]),
      .delay_time_2 (d2[AW-1:0]),
      .delay_time_3 (d3[AW-1:0]),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .tap1_out     (tap1),
      .tap2_out     (tap2),
      .tap3_out     (tap3),
      .taps_valid   (taps_valid),
      .busy         (busy),
      .overrun      (overrun)
    );

    // Single-port RAM, read-before-write, random power-up contents.
    logic [15:0] ram [DEPTH];
    bit          ram_init;
    always @(posedge clk) begin
      if (!ram_init) begin
        for (int i = 0; i < DEPTH; i++) ram[i] <= 16'($urandom);
        ram_init <= 1'b1;
      end else if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
    end

    // Reference model: every accepted sample is appended to hist; a tap with
    // delay d returns the sample d positions back, or 0 if that far back
    // has not been filled since reset.
    longint   hist [0:4095];
    int       nacc  = 0;
    int       last  = -100;
    int       cyc_l = 0;
    bit       ovr   = 1'b0;
    int       n, dd1, dd2, dd3;
    tap_exp_t expq [$];
    wr_exp_t  wq   [$];
    tap_exp_t e;
    wr_exp_t  w;

    always @(posedge clk) begin
      cyc_l++;
      if (!rst_) begin
        nacc = 0;
        last = -100;
        ovr  = 1'b0;
        expq.delete();
        wq.delete();
      end else if (sample_valid) begin
        if (cyc_l - last >= 6 && nacc < 4096) begin
          hist[nacc] = longint'($signed(sample_in));
          n   = (nacc < DEPTH - 1) ? nacc : DEPTH - 1;
          dd1 = int'(d1[AW-1:0]);
          dd2 = int'(d2[AW-1:0]);
          dd3 = int'(d3[AW-1:0]);
          e.t1  = (dd1 <= n) ? hist[nacc - dd1] : 0;
          e.t2  = (dd2 <= n) ? hist[nacc - dd2] : 0;
          e.t3  = (dd3 <= n) ? hist[nacc - dd3] : 0;
          e.cyc = cyc_l + 5;
          expq.push_back(e);
          w.addr = nacc % DEPTH;
          w.data = hist[nacc];
          w.cyc  = cyc_l;
          wq.push_back(w);
          nacc++;
          last = cyc_l;
        end else begin
          ovr = 1'b1;
        end
      end
    end

    // Monitor
    tap_exp_t e2;
    wr_exp_t  w2;
    bit       exp_we, exp_tv;

    always @(negedge clk) begin
      if (cyc_l >= 1) begin
        chk("busy", gi, busy, ((cyc_l - last) <= 4));
        chk("overrun", gi, overrun, ovr);

        exp_we = (wq.size() != 0) && (wq[0].cyc == cyc_l);
        chk("mem_we", gi, mem_we, exp_we);
        if (exp_we) begin
          w2 = wq.pop_front();
          chk("wr_addr", gi, mem_addr, w2.addr);
          chk("wr_data", gi, $signed(mem_wdata), w2.data);
        end

        exp_tv = (expq.size() != 0) && (expq[0].cyc == cyc_l);
        chk("taps_valid", gi, taps_valid, exp_tv);
        if (exp_tv) begin
          e2 = expq.pop_front();
          chk("tap1", gi, $signed(tap1), e2.t1);
          chk("tap2", gi, $signed(tap2), e2.t2);
          chk("tap3", gi, $signed(tap3), e2.t3);
          $display("[%0t] inst%0d taps %0d %0d %0d", $time, gi,
                   $signed(tap1), $signed(tap2), $signed(tap3));
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called right after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send(input logic [15:0] s, input int gap);
    sample_valid = 1'b1;
    sample_in    = s;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic set_delays(input int a, input int b, input int c);
    d1 = 12'(a);
    d2 = 12'(b);
    d3 = 12'(c);
  endtask

  task automatic do_reset(input int cycles);
    rst_ = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_ = 1'b1;
  endtask

  task automatic tap_check(input string nm, input longint a, input longint b, input longint c);
    chk({nm, "_t1"}, 0, $signed(g[0].tap1), a);
    chk({nm, "_t2"}, 0, $signed(g[0].tap2), b);
    chk({nm, "_t3"}, 0, $signed(g[0].tap3), c);
    chk({nm, "_t1"}, 1, $signed(g[1].tap1), a);
    chk({nm, "_t2"}, 1, $signed(g[1].tap2), b);
    chk({nm, "_t3"}, 1, $signed(g[1].tap3), c);
  endtask

  task automatic rst_check();
    chk("rst_tap1", 0, g[0].tap1, 0);
    chk("rst_tap2", 0, g[0].tap2, 0);
    chk("rst_tap3", 0, g[0].tap3, 0);
    chk("rst_addr", 0, g[0].mem_addr, 0);
    chk("rst_wdata", 0, g[0].mem_wdata, 0);
    chk("rst_tap1", 1, g[1].tap1, 0);
    chk("rst_tap2", 1, g[1].tap2, 0);
    chk("rst_tap3", 1, g[1].tap3, 0);
    chk("rst_addr", 1, g[1].mem_addr, 0);
    chk("rst_wdata", 1, g[1].mem_wdata, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst_         = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    set_delays(3, 2, 1);

    // Reset held with the strobe toggling.
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      sample_valid = ~sample_valid;
      sample_in    = 16'($urandom);
      @(negedge clk);
      rst_check();
    end
    sample_valid = 1'b0;
    rst_         = 1'b1;
    @(negedge clk);

    // First sample after reset.
    send(16'd100, 8);
    tap_check("first", 0, 0, 0);

    // Ramp 1..10.
    do_reset(2);
    for (int i = 1; i <= 10; i++) begin
      send(16'(i), 8);
      if (i == 3)  tap_check("ramp3", 0, 1, 2);
      if (i == 10) tap_check("ramp10", 7, 8, 9);
    end

    // Zero delay returns the current sample.
    set_delays(0, 0, 0);
    send(-16'sd5, 8);
    tap_check("d0_neg", -5, -5, -5);
    send(16'sd32767, 8);
    tap_check("d0_max", 32767, 32767, 32767);

    // Pointer wrap and fill saturation (visible on the ADDR_W=4 instance),
    // strobes at the minimum spacing.
    do_reset(2);
    set_delays(15, 0, 1);
    for (int i = 0; i < 20; i++) send(16'(i), 6);
    tap_check("wrap", 4, 19, 18);

    // Overrun: second strobe two cycles later is dropped.
    do_reset(2);
    set_delays(0, 0, 0);
    chk("ovr_clear", 0, g[0].overrun, 0);
    send(16'd11, 2);
    send(16'd22, 8);
    tap_check("ovr_first", 11, 11, 11);
    chk("ovr_set", 0, g[0].overrun, 1);
    chk("ovr_set", 1, g[1].overrun, 1);
    set_delays(0, 1, 2);
    send(16'd33, 8);
    tap_check("ovr_next", 33, 11, 0);
    chk("ovr_sticky", 0, g[0].overrun, 1);
    chk("ovr_sticky", 1, g[1].overrun, 1);

    // Reset during RD2: sequence aborts, next sample lands at address 0.
    sample_valid = 1'b1;
    sample_in    = 16'd44;
    @(negedge clk);               // WR
    sample_valid = 1'b0;
    @(negedge clk);               // RD1
    @(negedge clk);               // RD2
    rst_ = 1'b0;
    @(negedge clk);
    rst_ = 1'b1;
    chk("midrst_ovr", 0, g[0].overrun, 0);
    chk("midrst_ovr", 1, g[1].overrun, 0);
    repeat (6) @(negedge clk);
    send(16'd55, 8);
    tap_check("midrst_next", 55, 0, 0);

    // Randomized traffic with delay changes mid-sequence and overruns.
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        set_delays(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 4095)));
      end else begin
        set_delays(int'($urandom_range(0, 40)), int'($urandom_range(0, 40)),
                   int'($urandom_range(0, 15)));
      end
      sample_valid = 1'b1;
      sample_in    = 16'($urandom);
      @(negedge clk);
      sample_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        set_delays(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 4095)));
      end
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end

    repeat (12) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
